// File: rtl/dualrail_pkg.sv
// Shared types and constants for the dual-rail sweep driver.
// Holds the FSM state enum, vector sizing and the gate's golden truth table.
package dualrail_pkg;

    localparam int VEC_W   = 4;
    localparam int NUM_VEC = 16;

    // Golden truth table of the 4-input complex gate, bit i = out for {A,B,C,D}=i.
    localparam logic [NUM_VEC-1:0] EXP_TT = 16'hFC51;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_DONE
    } state_t;

endpackage

// File: rtl/dualrail_encoder.sv
// Combinational 4-bit vector to dual-rail encoder.
// Each true rail is a vector bit, each complement rail its inverse.
module dualrail_encoder
    import dualrail_pkg::*;
(
    input  logic [VEC_W-1:0] vec,
    output logic             a,
    output logic             not_a,
    output logic             b,
    output logic             not_b,
    output logic             c,
    output logic             not_c,
    output logic             d,
    output logic             not_d
);

    // Rails are derived from a single source so pairs can never disagree.
    always_comb begin
        a     = vec[3];
        not_a = ~vec[3];
        b     = vec[2];
        not_b = ~vec[2];
        c     = vec[1];
        not_c = ~vec[1];
        d     = vec[0];
        not_d = ~vec[0];
    end

endmodule

// File: rtl/dualrail_sweep_driver.sv
// Stimulus-and-capture stage for the dual-rail complex gate.
// Drives rails from a registered vector, waits SETTLE cycles, samples out.
module dualrail_sweep_driver
    import dualrail_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                single,
    input  logic                abort,
    input  logic [VEC_W-1:0]    vec_in,
    output logic                A,
    output logic                not_A,
    output logic                B,
    output logic                not_B,
    output logic                C,
    output logic                not_C,
    output logic                D,
    output logic                not_D,
    input  logic                gate_out,
    output logic                busy,
    output logic                done,
    output logic [NUM_VEC-1:0]  tt,
    output logic                result
);

    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);
    localparam logic [VEC_W-1:0] VEC_LAST = 4'hF;

    state_t               state_q, state_d;
    logic [VEC_W-1:0]     vec_q, vec_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 sweep_q, sweep_d;
    logic [NUM_VEC-1:0]   tt_q, tt_d;
    logic                 result_q, result_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;

    // Next-state logic: abort beats a capture due on the same edge.
    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        cnt_d    = cnt_q;
        sweep_d  = sweep_q;
        tt_d     = tt_q;
        result_d = result_q;
        done_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    vec_d   = single ? vec_in : '0;
                    cnt_d   = CNT_INIT;
                    sweep_d = ~single;
                    if (!single) begin
                        tt_d = '0;
                    end
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    tt_d[vec_q] = gate_out;
                    result_d    = gate_out;
                    if (sweep_q && (vec_q != VEC_LAST)) begin
                        vec_d = vec_q + 4'd1;
                        cnt_d = CNT_INIT;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            vec_q    <= '0;
            cnt_q    <= '0;
            sweep_q  <= 1'b0;
            tt_q     <= '0;
            result_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            cnt_q    <= cnt_d;
            sweep_q  <= sweep_d;
            tt_q     <= tt_d;
            result_q <= result_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    dualrail_encoder u_enc (
        .vec   (vec_q),
        .a     (A),
        .not_a (not_A),
        .b     (B),
        .not_b (not_B),
        .c     (C),
        .not_c (not_C),
        .d     (D),
        .not_d (not_D)
    );

    assign busy   = busy_q;
    assign done   = done_q;
    assign tt     = tt_q;
    assign result = result_q;

endmodule

// File: tb/tb_dualrail_sweep_driver.sv
// Bench for dualrail_sweep_driver with SETTLE=2 and SETTLE=1 instances.
// A behavioural gate model closes the loop from rails back to gate_out.
module tb_dualrail_sweep_driver;

    logic clk = 1'b0;
    logic rst, single, abort, start1, start2;
    logic [3:0] vec_in;
    logic [15:0] gate_tbl = 16'hFC51;

    logic a2, na2, b2, nb2, c2, nc2, d2, nd2, g2, busy2, done2, res2;
    logic a1, na1, b1, nb1, c1, nc1, d1, nd1, g1, busy1, done1, res1;
    logic [15:0] tt2, tt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign g2 = gate_tbl[{a2, b2, c2, d2}];
    assign g1 = gate_tbl[{a1, b1, c1, d1}];

    dualrail_sweep_driver #(.SETTLE(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .single(single),
        .abort(abort), .vec_in(vec_in),
        .A(a2), .not_A(na2), .B(b2), .not_B(nb2),
        .C(c2), .not_C(nc2), .D(d2), .not_D(nd2),
        .gate_out(g2), .busy(busy2), .done(done2),
        .tt(tt2), .result(res2)
    );

    dualrail_sweep_driver #(.SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .single(single),
        .abort(abort), .vec_in(vec_in),
        .A(a1), .not_A(na1), .B(b1), .not_B(nb1),
        .C(c1), .not_C(nc1), .D(d1), .not_D(nd1),
        .gate_out(g1), .busy(busy1), .done(done1),
        .tt(tt1), .result(res1)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Rail pairs must be complementary every cycle, in both instances.
    always @(negedge clk) begin
        checks++;
        if ({a2, b2, c2, d2} !== ~{na2, nb2, nc2, nd2} ||
            {a1, b1, c1, d1} !== ~{na1, nb1, nc1, nd1}) begin
            errors++;
            $display("FAIL rail_pair: t=%0t r2=%b%b%b%b n2=%b%b%b%b r1=%b%b%b%b n1=%b%b%b%b",
                     $time, a2, b2, c2, d2, na2, nb2, nc2, nd2,
                     a1, b1, c1, d1, na1, nb1, nc1, nd1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] rails2();
        return {a2, b2, c2, d2};
    endfunction

    // Starts an operation and returns the edge index (after E0) where done is seen.
    task automatic run_op(input bit sel, input bit sgl, input logic [3:0] v,
                          output int k);
        @(negedge clk);
        single = sgl;
        vec_in = v;
        if (sel) start1 = 1'b1;
        else start2 = 1'b1;
        tick();
        start1 = 1'b0;
        start2 = 1'b0;
        k = -1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if ((sel ? done1 : done2) === 1'b1) begin
                k = i;
                break;
            end
        end
    endtask

    typedef struct {
        logic [3:0] vin;
        logic       exp_res;
    } vec_t;

    vec_t tbl[6];
    int k;
    logic [15:0] exp_tt;

    initial begin
        tbl[0] = '{4'b1001, 1'b0};
        tbl[1] = '{4'b0100, 1'b1};
        tbl[2] = '{4'b0000, 1'b1};
        tbl[3] = '{4'b1111, 1'b1};
        tbl[4] = '{4'b0111, 1'b0};
        tbl[5] = '{4'b1010, 1'b1};

        rst = 1'b1;
        single = 1'b0;
        abort = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        vec_in = 4'd0;
        repeat (2) tick();
        rst = 1'b0;
        repeat (5) tick();
        chk("reset_rails", rails2(), 4'h0);
        chk("reset_tt", tt2, 16'h0);
        chk("reset_busy", busy2, 1'b0);
        chk("reset_done", done2, 1'b0);
        chk("reset_result", res2, 1'b0);

        exp_tt = 16'h0;
        for (int i = 0; i < 6; i++) begin
            run_op(1'b0, 1'b1, tbl[i].vin, k);
            exp_tt[tbl[i].vin] = tbl[i].exp_res;
            chk($sformatf("single%0d_latency", i), k, 2);
            chk($sformatf("single%0d_result", i), res2, tbl[i].exp_res);
            chk($sformatf("single%0d_tt", i), tt2, exp_tt);
            chk($sformatf("single%0d_rails", i), rails2(), tbl[i].vin);
            tick();
            chk($sformatf("single%0d_busy_off", i), busy2, 1'b0);
        end
        chk("single_tt_final", tt2, 16'h8411);

        run_op(1'b0, 1'b0, 4'd0, k);
        chk("sweep2_latency", k, 32);
        chk("sweep2_tt", tt2, 16'hFC51);
        chk("sweep2_result", res2, 1'b1);
        chk("sweep2_busy_done", busy2, 1'b1);
        tick();
        chk("sweep2_busy_off", busy2, 1'b0);
        chk("sweep2_done_pulse", done2, 1'b0);

        @(negedge clk);
        single = 1'b0;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("abort_tt_cleared", tt2, 16'h0);
        repeat (10) tick();
        chk("abort_pre_vec", rails2(), 4'h5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy2, 1'b0);
        chk("abort_done", done2, 1'b0);
        chk("abort_rails", rails2(), 4'h5);
        chk("abort_tt", tt2, 16'h0011);
        repeat (3) tick();
        chk("abort_hold_rails", rails2(), 4'h5);
        chk("abort_hold_busy", busy2, 1'b0);
        chk("abort_hold_done", done2, 1'b0);

        @(negedge clk);
        single = 1'b0;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        repeat (4) tick();
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        repeat (13) tick();
        chk("repulse_vec9", rails2(), 4'h9);
        chk("repulse_busy", busy2, 1'b1);
        chk("repulse_tt_partial", tt2, 16'h0051);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_rails", rails2(), 4'h0);
        chk("rst_tt", tt2, 16'h0);
        chk("rst_busy", busy2, 1'b0);
        chk("rst_done", done2, 1'b0);
        chk("rst_result", res2, 1'b0);

        run_op(1'b1, 1'b0, 4'd0, k);
        chk("sweep1_latency", k, 16);
        chk("sweep1_tt", tt1, 16'hFC51);
        chk("sweep1_result", res1, 1'b1);
        chk("sweep1_rails", {a1, b1, c1, d1}, 4'hF);
        tick();
        chk("sweep1_busy_off", busy1, 1'b0);
        chk("sweep1_done_pulse", done1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
